// File: rtl/final_core.sv
// Accumulator with a registered threshold-steered select: x takes b once the
// running sum of a has passed THRESHOLD, otherwise it takes a.
module final_core #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned THRESHOLD = 10
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] x
);

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    logic [WIDTH-1:0] accum_q, accum_d;
    logic [WIDTH-1:0] x_q, x_d;

    // Select uses the pre-edge accumulator; the sum wraps modulo 2^WIDTH.
    always_comb begin
        accum_d = accum_q + a;
        x_d     = (accum_q > THR) ? b : a;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            accum_q <= '0;
            x_q     <= '0;
        end else begin
            accum_q <= accum_d;
            x_q     <= x_d;
        end
    end

    assign x = x_q;

endmodule

// File: tb/tb_final_core.sv
// Scoreboard bench for final_core: expected x values are queued as stimulus is
// driven and compared one cycle later, after the capturing edge.
module tb_final_core;

    localparam int unsigned W  = 32;
    localparam int unsigned TH = 10;

    logic         clk = 1'b0;
    logic         reset_l = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] x;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] macc = '0;

    final_core #(.WIDTH(W), .THRESHOLD(TH)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .a       (a),
        .b       (b),
        .x       (x)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected x, compare after the edge.
    task automatic step(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] expx);
        logic [W-1:0] e;
        @(negedge clk);
        a = av;
        b = bv;
        sb.push_back(expx);
        macc = macc + av;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL %s: scoreboard empty got 0x%08h expected entry", tag, x);
        end else begin
            e = sb.pop_front();
            check(tag, x, e);
        end
    endtask

    // Assert reset between edges, confirm x clears without a clock, then release.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 reset_l = 1'b0;
        #1 check(tag, x, '0);
        macc = '0;
        a = '0;
        b = '0;
        @(negedge clk);
        reset_l = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ra, rb, ex;

        #1 reset_l = 1'b0;
        #1 check("por_x", x, '0);
        repeat (2) @(negedge clk);
        reset_l = 1'b1;

        // Async reset with x nonzero, then a = 0 keeps x at 0.
        step("pre_async", 32'd3, 32'd9, 32'd3);
        check("pre_async_nz", x, 32'd3);
        reset_pulse("async_clear");
        for (int i = 0; i < 3; i++) step("post_async_zero", 32'd0, 32'd77, 32'd0);

        // Threshold crossing: accum 0..10 selects a, 11 onward selects b.
        reset_pulse("rst_thr");
        for (int i = 0; i < 15; i++)
            step("thr_cross", 32'd1, 32'd100, (i < 11) ? 32'd1 : 32'd100);

        // Reset mid-run: same sequence must restart from scratch.
        reset_pulse("midrun_clear");
        for (int i = 0; i < 13; i++)
            step("thr_restart", 32'd1, 32'd100, (i < 11) ? 32'd1 : 32'd100);

        // Equality: accum == 10 still selects a.
        reset_pulse("rst_eq");
        for (int i = 0; i < 5; i++)
            step("eq_boundary", 32'd5, 32'd7, (i < 3) ? 32'd5 : 32'd7);

        // Wrap-around: accum alternates 0, 0x80000000.
        reset_pulse("rst_wrap");
        for (int i = 0; i < 6; i++)
            step("wrap", 32'h8000_0000, 32'hDEAD_BEEF,
                 (i % 2 == 0) ? 32'h8000_0000 : 32'hDEAD_BEEF);

        // Zero operand for 20 edges; then prove accum stayed 0.
        reset_pulse("rst_zero");
        for (int i = 0; i < 20; i++) step("zero_op", 32'd0, 32'h1234, 32'd0);
        step("zero_acc_a", 32'd11, 32'h55, 32'd11);
        step("zero_acc_b", 32'd0, 32'h55, 32'h55);

        // Random traffic checked against a reference accumulator.
        reset_pulse("rst_rand");
        for (int i = 0; i < 200; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
            rb = W'($urandom);
            ex = (macc > W'(TH)) ? rb : ra;
            step("random", ra, rb, ex);
        end

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/final_core.md
FINAL_CORE -- requirements
Module: final_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which is the data width of a, b, x and the accumulator.
REQ-002 The block SHALL have parameter THRESHOLD, default 10, an unsigned compare limit for the accumulator.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_l, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port a, input, WIDTH bits: accumulate operand and low-path select data.
REQ-006 The block SHALL have port b, input, WIDTH bits: high-path select data.
REQ-007 The block SHALL have port x, output, WIDTH bits: registered result.

Function
REQ-008 The block SHALL hold an internal WIDTH-bit unsigned accumulator, accum.
REQ-009 On each rising clk edge with reset_l high, accum SHALL become (accum + a) mod 2^WIDTH; no saturation and no carry output.
REQ-010 On the same edge, x SHALL become b if the pre-edge accum > THRESHOLD (unsigned compare), else a.
REQ-011 The select decision SHALL use the accum value before that edge's addition, not the updated value.
REQ-012 x SHALL be driven directly from a flop with no combinational path from a or b, giving 1-cycle latency from the sampled inputs.
REQ-013 When accum equals THRESHOLD exactly, the low path (a) SHALL be selected.
REQ-014 When the sum wraps past 2^WIDTH-1, accum SHALL take the truncated value, and the selection on the next edge SHALL follow the wrapped value.
REQ-015 The block SHALL have no enable, handshake or back-pressure: every clock edge out of reset is an active cycle.
REQ-016 The design SHALL be synthesizable, with no initial blocks, no X sources, and no latches.

Reset
REQ-017 While reset_l is low, accum and x SHALL be 0, asserted asynchronously and without needing a clock edge.
REQ-018 Reset deassertion SHALL be synchronized to clk; the first active edge is the first rising clk edge with reset_l sampled high.
REQ-019 Reset asserted mid-operation SHALL discard all accumulated state immediately; on release, operation restarts exactly as after power-up.

Verification
REQ-020 Async reset: drive x nonzero, pull reset_l low between clk edges -> x = 0 immediately, before the next edge; then release and apply a = 0 -> x stays 0.
REQ-021 Threshold crossing: after reset, hold a = 1, b = 100 -> x = 1 after edges 1..11 (pre-edge accum 0..10), x = 100 from edge 12 onward.
REQ-022 Equality boundary: after reset, hold a = 5, b = 7 -> x = 5, 5, 5 after edges 1, 2, 3 (accum 0, 5, 10), then x = 7 from edge 4 (accum 15).
REQ-023 Wrap-around: after reset, hold a = 0x80000000, b = 0xDEADBEEF -> x = 0x80000000, 0xDEADBEEF, 0x80000000, 0xDEADBEEF, alternating as accum cycles between 0 and 0x80000000.
REQ-024 Zero operand: after reset, hold a = 0, b = 0x1234 for 20 edges -> x = 0 throughout and accum stays 0.
REQ-025 Reset mid-run: run the REQ-021 stimulus for 15 edges (x = 100), then pulse reset_l low -> x = 0; after release, the same sequence restarts (x = 1 for edges 1..11).
